// File: rtl/chi_slice_if.sv
// Slice bus between the upstream slice source, the Chi stage and the iota stage.
//   inValid/in/inReady          : upstream slice handshake (25-bit slice, bit i = 5*y + x)
//   outValid/out/sliceIdx/outReady : Chi result handshake towards the iota stage
// slave  : view taken by the Chi stage
// master : view taken by the surrounding logic (or a testbench)
interface chi_slice_if;
    localparam int unsigned SLICE_W = 25;
    localparam int unsigned IDX_W   = 6;

    logic               inValid;
    logic [SLICE_W-1:0] in;
    logic               inReady;
    logic               outValid;
    logic [SLICE_W-1:0] out;
    logic [IDX_W-1:0]   sliceIdx;
    logic               outReady;

    modport slave (
        input  inValid, in, outReady,
        output inReady, outValid, out, sliceIdx
    );

    modport master (
        output inValid, in, outReady,
        input  inReady, outValid, out, sliceIdx
    );
endinterface

// File: rtl/chi_slice_stage.sv
// Slice-serial Keccak Chi step: one 25-bit slice per cycle, single-entry output
// register feeding the iota stage, pulses done when the last slice of a round is consumed.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   start : begin a round (sampled only in IDLE)
//   bus   : slice in/out handshakes (chi_slice_if.slave)
//   busy  : round in progress (RUN or DRAIN)
//   done  : one-cycle pulse on the final consume of a round (combinational)
module chi_slice_stage #(
    parameter int unsigned SLICES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    chi_slice_if.slave  bus,
    output logic        busy,
    output logic        done
);
    localparam int unsigned SLICE_W = 25;
    localparam int unsigned CNT_W   = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [SLICE_W-1:0] out_q, out_d;
    logic               vld_q, vld_d;

    logic in_ready_c;
    logic accept_c;
    logic consume_c;
    logic last_c;

    // Row-wise Chi using rotated copies of each 5-bit row: rot1[x]=row[x+1], rot2[x]=row[x+2].
    function automatic logic [SLICE_W-1:0] chi(input logic [SLICE_W-1:0] a);
        logic [SLICE_W-1:0] r;
        logic [4:0]         row;
        logic [4:0]         rot1;
        logic [4:0]         rot2;
        r = '0;
        for (int y = 0; y < 5; y++) begin
            row  = a[5*y +: 5];
            rot1 = {row[0], row[4:1]};
            rot2 = {row[1:0], row[4:2]};
            r[5*y +: 5] = row ^ (~rot1 & rot2);
        end
        return r;
    endfunction

    // Next-state, handshake and output-register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        out_d   = out_q;
        vld_d   = vld_q;

        in_ready_c = (state_q == RUN) && (!vld_q || bus.outReady);
        accept_c   = in_ready_c && bus.inValid;
        consume_c  = vld_q && bus.outReady;
        last_c     = (cnt_q == CNT_W'(SLICES - 1));

        // An accept reloads the register even when the old entry is consumed in the same cycle.
        if (accept_c) begin
            out_d = chi(bus.in);
            idx_d = cnt_q;
            vld_d = 1'b1;
            cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
        end else if (consume_c) begin
            vld_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    vld_d   = 1'b0;
                end
            end
            RUN: begin
                if (accept_c && last_c) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (consume_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.inReady  = in_ready_c;
    assign bus.outValid = vld_q;
    assign bus.out      = out_q;
    assign bus.sliceIdx = idx_q;
    assign busy         = (state_q == RUN) || (state_q == DRAIN);
    assign done         = (state_q == DRAIN) && consume_c;
endmodule

// File: tb/tb_chi_slice_stage.sv
// Directed testbench for chi_slice_stage (SLICES=64).
module tb_chi_slice_stage;
    localparam int unsigned SLICES = 64;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic done;
    int   total;
    int   bad;

    chi_slice_if bus();

    chi_slice_stage #(.SLICES(SLICES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference Chi written directly from the row equation.
    function automatic logic [24:0] chi_ref(input logic [24:0] a);
        logic [24:0] r;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                r[5*y+x] = a[5*y+x] ^ (~a[5*y+((x+1)%5)] & a[5*y+((x+2)%5)]);
        return r;
    endfunction

    // Per-slice stimulus pattern.
    function automatic logic [24:0] pat(input int i);
        return 25'(32'(i) * 32'h0246_8ACF + 32'h0135_79BD);
    endfunction

    // Drive inputs just after a rising edge and let combinational outputs settle.
    task automatic tick(input logic v, input logic [24:0] d, input logic r, input logic s);
        @(posedge clk);
        #1;
        bus.inValid  = v;
        bus.in       = d;
        bus.outReady = r;
        start        = s;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0;
        bus.inValid = 1'b0; bus.in = '0; bus.outReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.inReady, bus.outValid, bus.out, bus.sliceIdx, busy, done} !== 35'd0) begin
            bad++;
            $display("FAIL reset_values got ir=%b ov=%b out=%h idx=%0d busy=%b done=%b want all 0",
                     bus.inReady, bus.outValid, bus.out, bus.sliceIdx, busy, done);
        end
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 25'h1ABCDEF, 1'b1, 1'b0);
            total++;
            if ({bus.inReady, bus.outValid, bus.out} !== 27'd0) begin
                bad++;
                $display("FAIL idle_no_start cyc=%0d got ir=%b ov=%b out=%h want 0 0 0",
                         i, bus.inReady, bus.outValid, bus.out);
            end
        end
    endtask

    task automatic test_single();
        logic [24:0] vin  [3];
        logic [24:0] vexp [3];
        vin[0]  = 25'h0000000; vin[1]  = 25'h0000002; vin[2]  = 25'h1FFFFFF;
        vexp[0] = 25'h0000000; vexp[1] = 25'h0000012; vexp[2] = 25'h1FFFFFF;
        tick(1'b0, '0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, vin[k], 1'b1, 1'b0);
            total++;
            if (bus.inReady !== 1'b1) begin
                bad++;
                $display("FAIL single_accept k=%0d got ir=%b want 1", k, bus.inReady);
            end
            tick(1'b0, '0, 1'b1, 1'b0);
            total++;
            if (bus.outValid !== 1'b1 || bus.out !== vexp[k] || bus.sliceIdx !== 6'(k) || done !== 1'b0) begin
                bad++;
                $display("FAIL single_chi k=%0d got ov=%b out=%h idx=%0d done=%b want 1 %h %0d 0",
                         k, bus.outValid, bus.out, bus.sliceIdx, done, vexp[k], k);
            end
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_stream();
        int nxt = 0, exp_i = 0, n_done = 0, first_acc = -1, done_cyc = -1, gaps = 0;
        tick(1'b0, '0, 1'b1, 1'b1);
        for (int c = 0; c < 200 && n_done == 0; c++) begin
            tick(nxt < SLICES, pat(nxt), 1'b1, 1'b0);
            if (bus.outValid && bus.outReady) begin
                total++;
                if (bus.sliceIdx !== 6'(exp_i) || bus.out !== chi_ref(pat(exp_i))) begin
                    bad++;
                    $display("FAIL stream_seq got idx=%0d out=%h want idx=%0d out=%h",
                             bus.sliceIdx, bus.out, exp_i, chi_ref(pat(exp_i)));
                end
                exp_i++;
            end else if (exp_i > 0) begin
                gaps++;
            end
            if (done) begin
                n_done++;
                done_cyc = c;
                total++;
                if (bus.sliceIdx !== 6'd63) begin
                    bad++;
                    $display("FAIL stream_done_idx got idx=%0d want 63", bus.sliceIdx);
                end
            end
            if (bus.inValid && bus.inReady) begin
                if (first_acc < 0) first_acc = c;
                nxt++;
            end
        end
        total++;
        if (exp_i != 64 || n_done != 1 || gaps != 0) begin
            bad++;
            $display("FAIL stream_count got slices=%0d dones=%0d gaps=%0d want 64 1 0", exp_i, n_done, gaps);
        end
        total++;
        if (done_cyc - first_acc + 1 != 65) begin
            bad++;
            $display("FAIL stream_latency got cycles=%0d want 65", done_cyc - first_acc + 1);
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        total++;
        if ({busy, bus.outValid, bus.inReady, done} !== 4'b0000) begin
            bad++;
            $display("FAIL stream_idle_after got busy=%b ov=%b ir=%b done=%b want 0 0 0 0",
                     busy, bus.outValid, bus.inReady, done);
        end
    endtask

    task automatic test_backpressure();
        int nxt = 0, exp_i = 0, n_done = 0, stall = 0, stall_seen = 0;
        tick(1'b0, '0, 1'b1, 1'b1);
        for (int c = 0; c < 300 && n_done == 0; c++) begin
            tick(nxt < SLICES, pat(nxt), stall == 0, 1'b0);
            if (stall > 0) begin
                stall--;
                stall_seen++;
                total++;
                if (bus.inReady !== 1'b0 || bus.outValid !== 1'b1 || bus.sliceIdx !== 6'd17 ||
                    bus.out !== chi_ref(pat(17))) begin
                    bad++;
                    $display("FAIL bp_hold got ir=%b ov=%b idx=%0d out=%h want 0 1 17 %h",
                             bus.inReady, bus.outValid, bus.sliceIdx, bus.out, chi_ref(pat(17)));
                end
            end
            if (bus.outValid && bus.outReady) begin
                total++;
                if (bus.sliceIdx !== 6'(exp_i) || bus.out !== chi_ref(pat(exp_i))) begin
                    bad++;
                    $display("FAIL bp_seq got idx=%0d out=%h want idx=%0d out=%h",
                             bus.sliceIdx, bus.out, exp_i, chi_ref(pat(exp_i)));
                end
                exp_i++;
            end
            if (done) n_done++;
            if (bus.inValid && bus.inReady) begin
                nxt++;
                if (nxt == 18) stall = 5;
            end
        end
        total++;
        if (exp_i != 64 || n_done != 1 || stall_seen != 5) begin
            bad++;
            $display("FAIL bp_count got slices=%0d dones=%0d stalls=%0d want 64 1 5", exp_i, n_done, stall_seen);
        end
    endtask

    task automatic test_start_ignored();
        int nxt = 0, exp_i = 0, n_done = 0, last_idx = -1;
        tick(1'b0, '0, 1'b1, 1'b1);
        for (int c = 0; c < 200 && n_done == 0; c++) begin
            tick(nxt < SLICES, pat(nxt), 1'b1, nxt == 30);
            if (bus.outValid && bus.outReady) begin
                total++;
                if (bus.sliceIdx !== 6'(exp_i)) begin
                    bad++;
                    $display("FAIL start_seq got idx=%0d want %0d", bus.sliceIdx, exp_i);
                end
                last_idx = int'(bus.sliceIdx);
                exp_i++;
            end
            if (done) n_done++;
            if (bus.inValid && bus.inReady) nxt++;
        end
        for (int c = 0; c < 4; c++) begin
            tick(1'b1, pat(c), 1'b1, 1'b0);
            if (done) n_done++;
        end
        total++;
        if (last_idx != 63 || n_done != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL start_ignored got last=%0d dones=%0d busy=%b want 63 1 0", last_idx, n_done, busy);
        end
    endtask

    task automatic test_reset_mid();
        int nxt = 0, n_done = 0;
        logic hit = 1'b0;
        tick(1'b0, '0, 1'b1, 1'b1);
        for (int c = 0; c < 200 && !hit; c++) begin
            tick(nxt < SLICES, pat(nxt), 1'b1, 1'b0);
            if (done) n_done++;
            if (bus.outValid && bus.sliceIdx == 6'd40) hit = 1'b1;
            else if (bus.inValid && bus.inReady) nxt++;
        end
        total++;
        if (hit !== 1'b1 || n_done != 0) begin
            bad++;
            $display("FAIL rstmid_reach got hit=%b dones=%0d want 1 0", hit, n_done);
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if ({bus.inReady, bus.outValid, bus.out, bus.sliceIdx, busy, done} !== 35'd0) begin
            bad++;
            $display("FAIL rstmid_async got ir=%b ov=%b out=%h idx=%0d busy=%b done=%b want all 0",
                     bus.inReady, bus.outValid, bus.out, bus.sliceIdx, busy, done);
        end
        @(posedge clk);
        #1;
        total++;
        if ({bus.outValid, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL rstmid_hold got ov=%b busy=%b done=%b want 0 0 0", bus.outValid, busy, done);
        end
        @(negedge clk) rst = 1'b1;
        test_stream();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/chi_slice_stage.md
# chi_slice_stage

Slice-serial Chi step of the Keccak-f[1600] round, sitting directly upstream of the AddRc (iota) stage. It accepts one 25-bit state slice per cycle over a valid/ready handshake and applies the Chi nonlinearity row-wise. It registers each result and presents it to the iota stage together with the slice index. After all slices of a round pass through, it pulses `done` so the round controller can advance `cycleNum`.

## Interface
- `SLICES`, 64, slices per round (lane width). Legal values are powers of two, 2..64. The counter is always 6 bits wide.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset: `rst`=0 clears all state immediately, independent of `clk`.
- `start`  in  1  one-cycle request to begin a round; sampled only in IDLE.
- `inValid`  in  1  upstream slice on `in` is valid.
- `in`  in  25  input slice, bit index i = 5*y + x, with x,y in 0..4.
- `outReady`  in  1  downstream (iota stage) accepts `out` this cycle.
- `inReady`  out  1  this stage accepts `in` this cycle.
- `outValid`  out  1  `out`/`sliceIdx` hold a valid result.
- `out`  out  25  Chi result slice, same bit mapping as `in`.
- `sliceIdx`  out  6  slice number (0..SLICES-1) of the slice currently held in `out`.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse when the last slice of the round is consumed.

## Operation
- Chi, per row y and each x: `out[5y+x] = in[5y+x] ^ (~in[5y+(x+1)%5] & in[5y+(x+2)%5])`. Indices wrap mod 5 within the row. No carries, no cross-row terms.
- FSM states are IDLE, RUN, DRAIN.
  - IDLE → RUN on `start`=1. This clears the accept counter and the output register valid bit.
  - RUN: a slice is accepted when `inValid && inReady`. The accept counter increments on each accept. The accept that brings the count to SLICES moves the FSM to DRAIN.
  - DRAIN: no accepts (`inReady`=0). When `outValid && outReady`, the FSM goes to IDLE and `done`=1 in that same cycle.
- `inReady` = (state==RUN) && (!outValid || outReady). This gives a single-entry pipeline with full throughput under continuous `outReady`.
- Output register load: on accept, `out` ← Chi(`in`), `sliceIdx` ← accept count before increment, `outValid` ← 1.
- On a handshake (`outValid && outReady`) with no accept in the same cycle, `outValid` ← 0.
- Simultaneous accept and consume in one cycle: the register reloads with the new slice and `outValid` stays 1.
- While `outValid`=1 and `outReady`=0, `out` and `sliceIdx` are held stable.
- `start` is ignored outside IDLE.
- `inValid` is ignored outside RUN.
- `done` is only ever asserted on the final consume of a round.

## Timing
- Reset values: `inReady`=0, `outValid`=0, `out`=0, `sliceIdx`=0, `busy`=0, `done`=0. FSM in IDLE, counter=0.
- Latency is 1 cycle: a slice accepted at edge k appears on `out` with `outValid`=1 after edge k.
- Throughput: 1 slice/cycle when `outReady` is held high. A round takes SLICES+1 cycles from the first accept to `done`.
- `start` at edge k gives `inReady`=1 after edge k (provided `outValid`=0, which IDLE guarantees).
- `done` is combinational from state==DRAIN && `outValid` && `outReady`. It is high for exactly one cycle per round.
- Reset asserted mid-round: all state clears asynchronously. A partial round is discarded, with no `done`.
- Counter wrap: the counter never exceeds SLICES-1 as an index. With SLICES=64, the 6-bit counter returns to 0 on round end.

## Test plan
- Reset then idle: after `rst` is released, drive `inValid`=1 without `start` → `inReady`=0, `outValid`=0, `out`=0 for 10 cycles.
- Single-slice Chi values:
  - `in`=25'h0000000 → `out`=25'h0000000.
  - `in`=25'h0000002 (x=1,y=0) → `out`=25'h0000012.
  - `in`=25'h1FFFFFF → `out`=25'h1FFFFFF.
  - In each case `sliceIdx` matches the accept order.
- Full round, streaming: `start`, then 64 slices with `inValid`=`outReady`=1 → 64 consecutive `outValid` cycles with `sliceIdx` 0..63, and `done` high exactly once, on the slice-63 consume cycle 65 cycles after the first accept.
- Backpressure: hold `outReady`=0 for 5 cycles mid-round at slice 17 → `inReady`=0, and `out`/`sliceIdx`=17 stay stable. After release, slices resume at 18 with no loss or duplication.
- Start during RUN is ignored: pulse `start` at slice 30 → the counter continues to 63, and only one `done` is produced.
- Reset mid-round: assert `rst`=0 at slice 40 → outputs go to reset values immediately with no `done`. A fresh `start` then runs a full round beginning at `sliceIdx`=0.
